vga_palette_scanout: RTL
========================

Name: vga_palette_scanout

Overview:
Parametrised successor to the fixed 800x600 paletted VGA controller. It generates VGA timing from parameters and issues linear framebuffer read addresses incrementally, with no multiplier. Each fetched index is mapped through an internal writable palette, or the fetched pixel bypasses the palette in direct mode. HS, VS and blank_n are delayed so they line up exactly with the RGB pipeline. The block sits between the framebuffer RAM and the DAC/VGA pins.

Parameters:
H_VISIBLE, 800, active pixels per line
H_FRONT, 56, front porch in clocks
H_SYNC, 120, sync pulse width in clocks
H_BACK, 64, back porch in clocks
V_VISIBLE, 600, active lines
V_FRONT, 37, vertical front porch in lines
V_SYNC, 6, vertical sync width in lines
V_BACK, 23, vertical back porch in lines
SYNC_ACTIVE_LOW, 1, 1 = HS/VS asserted low
INDEX_W, 8, palette index width; palette depth is 2^INDEX_W
FB_ADDR_W, 19, framebuffer address width
FB_LATENCY, 2, framebuffer read latency in clocks (>=1)
SCALE_SHIFT, 0, pixel/line replication factor 2^SCALE_SHIFT (0..2)

Ports:
vga_clk  input  1  pixel clock, the only clock
reset  input  1  asynchronous, active-high
enable  input  1  1 = scan out; 0 = counters held at 0, outputs blanked
mode_direct  input  1  1 = fb_data[23:0] drives RGB directly; 0 = paletted
fb_addr  output  FB_ADDR_W  framebuffer read address
fb_data  input  24  framebuffer read data, valid FB_LATENCY clocks after fb_addr
pal_we  input  1  palette write strobe
pal_addr  input  INDEX_W  palette write address
pal_wdata  input  24  palette entry, {R,G,B}
HS  output  1  horizontal sync, pipeline-aligned
VS  output  1  vertical sync, pipeline-aligned
blank_n  output  1  1 = visible pixel, pipeline-aligned
frame_start  output  1  one-cycle pulse when h=0,v=0 is issued (unaligned)
red  output  8  pixel red
green  output  8  pixel green
blue  output  8  pixel blue

Behaviour:
- Reset state: counters 0, fb_addr 0, frame_start 0, blank_n 0, RGB 0, HS/VS inactive (1 when SYNC_ACTIVE_LOW), all delay stages cleared. Palette contents are not reset.
- Line period: H_TOTAL = sum of the four H parameters (1040). Frame period: V_TOTAL lines (666).
- h_cnt increments 0..H_TOTAL-1 and wraps. v_cnt increments when h_cnt wraps, 0..V_TOTAL-1.
- Visible region: h < H_VISIBLE and v < V_VISIBLE.
- HS asserted for h in [H_VISIBLE+H_FRONT, +H_SYNC). VS asserted for v in [V_VISIBLE+V_FRONT, +V_SYNC).
- FB_W = H_VISIBLE>>SCALE_SHIFT. fb_addr = line_base + (h>>SCALE_SHIFT) while visible.
- line_base is 0 at frame start and advances by FB_W after every 2^SCALE_SHIFT visible lines. Computed by registered adder only.
- fb_addr holds its last value outside the visible region. Maximum address is FB_W*(V_VISIBLE>>SCALE_SHIFT)-1; it wraps to 0 at the next frame.
- Pipeline:
  - cycle 0: fb_addr registered.
  - FB_LATENCY: fb_data arrives.
  - +1: palette read, read-first.
  - +1: output register.
  - Total latency L = FB_LATENCY+2 from the counter value to red/green/blue.
- HS, VS and blank_n pass through an L-stage shift register so all pins change on the same edge as the pixel they describe.
- RGB is forced to 0 when the delayed blank_n is 0.
- Palette is single-clock, read-first, indexed by fb_data[INDEX_W-1:0]. A pal_we write to the index being read in the same cycle returns the old entry; the new entry is visible from the next read.
- mode_direct is sampled only at frame_start. A change mid-frame takes effect from the next frame. Direct mode still applies latency L (palette stage becomes a register).
- enable=0: counters, line_base and fb_addr are synchronously held at 0, frame_start stays 0, and delay stages fill with blank/inactive values. RGB is 0 within L clocks.
- enable 0->1: the first cycle issues h=0,v=0 with a frame_start pulse.
- Reset mid-frame: immediate return to reset state. Scan restarts at h=0,v=0 on the first enabled clock after release.

Test Plan:
- Reset value check: assert reset mid-line -> HS=VS=1, blank_n=0, RGB=0, fb_addr=0 on the same cycle. After release with enable=1, frame_start pulses on the 1st clock.
- Timing, defaults: count clocks -> HS low exactly 120 clocks per 1040-clock line; VS low for 6 lines (6240 clocks); frame_start period 692,640 clocks.
- Alignment: FB model returns data=addr[7:0] after 2 clocks; palette entry i = {i,~i,8'h55} -> first blank_n=1 cycle shows RGB=00/FF/55, the next cycle 01/FE/55. Last visible pixel of line 0 is index 799&FF=0x1F.
- SCALE_SHIFT=1: fb_addr sequence per line is 0,0,1,1,..,399,399; lines 0 and 1 identical; line 2 starts at 400; last frame address 119,999.
- Palette collision: pal_we to index 5 with new value on the cycle index 5 is read -> that pixel shows the old value, the next read of 5 shows the new value.
- Mode switch: toggle mode_direct at line 300 -> the rest of the frame stays paletted. The next frame outputs fb_data[23:0] directly, still with latency L.

Source files
------------

// File: rtl/vga_palette_scanout_if.sv
// Bus bundle between the paletted VGA scanout block, its framebuffer RAM,
// the palette-loading host and the DAC/VGA pins.
interface vga_palette_scanout_if #(
  parameter int INDEX_W   = 8,
  parameter int FB_ADDR_W = 19
);
  logic                 enable;
  logic                 mode_direct;
  logic [FB_ADDR_W-1:0] fb_addr;
  logic [23:0]          fb_data;
  logic                 pal_we;
  logic [INDEX_W-1:0]   pal_addr;
  logic [23:0]          pal_wdata;
  logic                 HS;
  logic                 VS;
  logic                 blank_n;
  logic                 frame_start;
  logic [7:0]           red;
  logic [7:0]           green;
  logic [7:0]           blue;

  // Scanout block side
  modport master (
    input  enable, mode_direct, fb_data, pal_we, pal_addr, pal_wdata,
    output fb_addr, HS, VS, blank_n, frame_start, red, green, blue
  );

  // Environment side: control, framebuffer RAM, palette host, pins
  modport slave (
    output enable, mode_direct, fb_data, pal_we, pal_addr, pal_wdata,
    input  fb_addr, HS, VS, blank_n, frame_start, red, green, blue
  );
endinterface

// File: rtl/vga_palette_scanout.sv
// Parametrised VGA timing generator with incremental linear framebuffer
// addressing, optional pixel/line replication, a writable read-first palette
// (or direct 24-bit bypass) and sync/blank delayed to match the RGB pipeline.
module vga_palette_scanout #(
  parameter int H_VISIBLE       = 800,
  parameter int H_FRONT         = 56,
  parameter int H_SYNC          = 120,
  parameter int H_BACK          = 64,
  parameter int V_VISIBLE       = 600,
  parameter int V_FRONT         = 37,
  parameter int V_SYNC          = 6,
  parameter int V_BACK          = 23,
  parameter int SYNC_ACTIVE_LOW = 1,
  parameter int INDEX_W         = 8,
  parameter int FB_ADDR_W       = 19,
  parameter int FB_LATENCY      = 2,
  parameter int SCALE_SHIFT     = 0
) (
  input logic                  vga_clk,
  input logic                  reset,
  vga_palette_scanout_if.master bus
);

  localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HW        = $clog2(H_TOTAL + 1);
  localparam int VW        = $clog2(V_TOTAL + 1);
  localparam int L         = FB_LATENCY + 2;
  localparam int FB_W      = H_VISIBLE >> SCALE_SHIFT;
  localparam int PAL_DEPTH = 1 << INDEX_W;

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS  = HW'(H_VISIBLE);
  localparam logic [HW-1:0] HS_ON  = HW'(H_VISIBLE + H_FRONT);
  localparam logic [HW-1:0] HS_OFF = HW'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [HW-1:0] H_MASK = HW'((1 << SCALE_SHIFT) - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS  = VW'(V_VISIBLE);
  localparam logic [VW-1:0] VS_ON  = VW'(V_VISIBLE + V_FRONT);
  localparam logic [VW-1:0] VS_OFF = VW'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [VW-1:0] V_MASK = VW'((1 << SCALE_SHIFT) - 1);
  localparam logic [FB_ADDR_W-1:0] FB_W_A = FB_ADDR_W'(FB_W);

  typedef enum logic {ST_IDLE, ST_SCAN} state_t;

  state_t               state;
  logic [HW-1:0]        h_cnt, h_nxt;
  logic [VW-1:0]        v_cnt, v_nxt;
  logic [FB_ADDR_W-1:0] line_base, lb_nxt;
  logic [FB_ADDR_W-1:0] fb_addr_p0, addr_nxt;
  logic                 start_nxt, vis_nxt;
  logic                 frame_start_r, mode_r;
  logic                 vis_cur, hs_cur, vs_cur;
  logic [L-1:0]         blank_sr, hs_sr, vs_sr;
  logic [L-2:0]         mode_sr;
  logic [23:0]          palette [PAL_DEPTH];
  logic [23:0]          pal_rgb_p1, fb_rgb_p1;
  logic [23:0]          rgb_p2;

  // Next counter position, line base and address. The first enabled cycle
  // after idle issues (0,0); addresses advance by one per replicated pixel.
  always_comb begin
    h_nxt     = '0;
    v_nxt     = '0;
    lb_nxt    = '0;
    addr_nxt  = '0;
    start_nxt = 1'b0;
    vis_nxt   = 1'b0;
    if (bus.enable) begin
      if (state == ST_SCAN) begin
        if (h_cnt == H_LAST) begin
          h_nxt = '0;
          v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end else begin
          h_nxt = h_cnt + 1'b1;
          v_nxt = v_cnt;
        end
      end
      start_nxt = (h_nxt == '0) && (v_nxt == '0);
      vis_nxt   = (h_nxt < H_VIS) && (v_nxt < V_VIS);
      if (start_nxt)
        lb_nxt = '0;
      else if ((h_cnt == H_LAST) && (v_cnt < V_VIS) && ((v_nxt & V_MASK) == '0))
        lb_nxt = line_base + FB_W_A;
      else
        lb_nxt = line_base;
      if (vis_nxt && (h_nxt == '0))
        addr_nxt = lb_nxt;
      else if (vis_nxt && ((h_nxt & H_MASK) == '0))
        addr_nxt = fb_addr_p0 + 1'b1;
      else
        addr_nxt = fb_addr_p0;
    end
  end

  // Scan state, counters and the issued address; mode latched at frame start
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      h_cnt         <= '0;
      v_cnt         <= '0;
      line_base     <= '0;
      fb_addr_p0    <= '0;
      frame_start_r <= 1'b0;
      mode_r        <= 1'b0;
    end else begin
      state         <= bus.enable ? ST_SCAN : ST_IDLE;
      h_cnt         <= h_nxt;
      v_cnt         <= v_nxt;
      line_base     <= lb_nxt;
      fb_addr_p0    <= addr_nxt;
      frame_start_r <= start_nxt;
      if (start_nxt)
        mode_r <= bus.mode_direct;
    end
  end

  assign vis_cur = (state == ST_SCAN) && (h_cnt < H_VIS) && (v_cnt < V_VIS);
  assign hs_cur  = (state == ST_SCAN) && (h_cnt >= HS_ON) && (h_cnt < HS_OFF);
  assign vs_cur  = (state == ST_SCAN) && (v_cnt >= VS_ON) && (v_cnt < VS_OFF);

  // Sync/blank/mode delay line matching the framebuffer + palette + output pipe
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      blank_sr <= '0;
      hs_sr    <= '0;
      vs_sr    <= '0;
      mode_sr  <= '0;
    end else begin
      blank_sr <= {blank_sr[L-2:0], vis_cur};
      hs_sr    <= {hs_sr[L-2:0], hs_cur};
      vs_sr    <= {vs_sr[L-2:0], vs_cur};
      mode_sr  <= {mode_sr[L-3:0], mode_r};
    end
  end

  // ---- stage p1: palette lookup (read-first) and direct-pixel register ----
  always_ff @(posedge vga_clk) begin
    if (bus.pal_we)
      palette[bus.pal_addr] <= bus.pal_wdata;
    pal_rgb_p1 <= palette[bus.fb_data[INDEX_W-1:0]];
    fb_rgb_p1  <= bus.fb_data;
  end

  // ---- stage p2: output register, blanked pixels forced to black ----
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset)
      rgb_p2 <= '0;
    else if (blank_sr[L-2])
      rgb_p2 <= mode_sr[L-2] ? fb_rgb_p1 : pal_rgb_p1;
    else
      rgb_p2 <= '0;
  end

  assign bus.fb_addr     = fb_addr_p0;
  assign bus.frame_start = frame_start_r;
  assign bus.blank_n     = blank_sr[L-1];
  assign bus.HS          = (SYNC_ACTIVE_LOW != 0) ? ~hs_sr[L-1] : hs_sr[L-1];
  assign bus.VS          = (SYNC_ACTIVE_LOW != 0) ? ~vs_sr[L-1] : vs_sr[L-1];
  assign bus.red         = rgb_p2[23:16];
  assign bus.green       = rgb_p2[15:8];
  assign bus.blue        = rgb_p2[7:0];

endmodule
